// File: rtl/axi_spi_pkg.sv
// Shared register offsets, CTRL field positions, engine states and AXI response codes
// for the AXI4-Lite SPI master.
package axi_spi_pkg;

    // Word index of each register, decoded from addr[4:2]
    localparam logic [2:0] RegCtrl   = 3'd0;
    localparam logic [2:0] RegDiv    = 3'd1;
    localparam logic [2:0] RegTxdata = 3'd2;
    localparam logic [2:0] RegRxdata = 3'd3;
    localparam logic [2:0] RegStatus = 3'd4;

    localparam int unsigned CtrlCpol  = 0;
    localparam int unsigned CtrlCpha  = 1;
    localparam int unsigned CtrlLsb   = 2;
    localparam int unsigned CtrlIrqEn = 3;
    localparam int unsigned CtrlCsLo  = 8;
    localparam int unsigned CtrlLenLo = 16;
    localparam logic [31:0] CtrlMask  = 32'h001F_070F;

    typedef logic [1:0] eng_state_t;
    localparam eng_state_t StIdle  = 2'd0;
    localparam eng_state_t StSetup = 2'd1;
    localparam eng_state_t StShift = 2'd2;
    localparam eng_state_t StHold  = 2'd3;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = strb[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_master_core.sv
// SPI engine: setup/shift/hold sequencing, SCK divider and the TX/RX shift registers.
// Configuration is clamped and latched when a transfer starts.
module spi_master_core #(
    parameter int unsigned CS_COUNT = 4,
    parameter int unsigned FRAME_W  = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                cpol,
    input  logic                cpha,
    input  logic                lsb_first,
    input  logic [2:0]          cs_sel,
    input  logic [4:0]          len_m1,
    input  logic [7:0]          div,
    input  logic [31:0]         txdata,
    input  logic                miso,
    output logic                busy,
    output logic                finish,
    output logic [31:0]         rxdata,
    output logic [CS_COUNT-1:0] cs,
    output logic                sck,
    output logic                mosi
);
    import axi_spi_pkg::*;

    localparam logic [4:0] LenMax = 5'(FRAME_W - 1);
    localparam logic [2:0] CsMax  = 3'(CS_COUNT - 1);

    eng_state_t  state_q;
    logic [7:0]  cnt_q, div_q;
    logic [5:0]  edge_q;
    logic [4:0]  len_q, len_c;
    logic [2:0]  cs_idx_q, cs_c;
    logic        cpha_q, lsb_q, sck_q, mosi_q;
    logic [31:0] tx_sr_q, rx_sr_q;
    logic        tick, last_edge, leading, sample, update, cur_bit, first_bit;

    always_comb begin
        len_c     = (len_m1 > LenMax) ? LenMax : len_m1;
        cs_c      = (cs_sel > CsMax) ? CsMax : cs_sel;
        first_bit = lsb_first ? txdata[0] : txdata[len_c];
        tick      = (cnt_q == div_q);
        last_edge = (edge_q == {len_q, 1'b1});
        leading   = ~edge_q[0];
        // cpha=0 samples on leading edges, cpha=1 on trailing edges
        sample    = tick && (state_q == StShift) && (leading ^ cpha_q);
        update    = tick && (state_q == StShift) &&
                    (cpha_q ? leading : (~leading && ~last_edge));
        cur_bit   = lsb_q ? tx_sr_q[0] : tx_sr_q[len_q];
        busy      = (state_q != StIdle);
        finish    = (state_q == StHold) && tick;
        rxdata    = rx_sr_q;
        sck       = sck_q;
        mosi      = mosi_q;
        for (int i = 0; i < CS_COUNT; i++) begin
            cs[i] = !(busy && (cs_idx_q == 3'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= 8'd0;
            div_q    <= 8'd0;
            edge_q   <= 6'd0;
            len_q    <= 5'd0;
            cs_idx_q <= 3'd0;
            cpha_q   <= 1'b0;
            lsb_q    <= 1'b0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            tx_sr_q  <= 32'd0;
            rx_sr_q  <= 32'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    sck_q <= cpol;
                    cnt_q <= 8'd0;
                    if (start) begin
                        state_q  <= StSetup;
                        len_q    <= len_c;
                        cs_idx_q <= cs_c;
                        cpha_q   <= cpha;
                        lsb_q    <= lsb_first;
                        div_q    <= div;
                        edge_q   <= 6'd0;
                        rx_sr_q  <= 32'd0;
                        if (!cpha) begin
                            mosi_q  <= first_bit;
                            tx_sr_q <= lsb_first ? (txdata >> 1) : (txdata << 1);
                        end else begin
                            tx_sr_q <= txdata;
                        end
                    end
                end
                StSetup: begin
                    if (tick) begin
                        cnt_q   <= 8'd0;
                        state_q <= StShift;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StShift: begin
                    if (tick) begin
                        cnt_q  <= 8'd0;
                        sck_q  <= ~sck_q;
                        edge_q <= edge_q + 6'd1;
                        if (last_edge) state_q <= StHold;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    if (tick) begin
                        cnt_q   <= 8'd0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
            endcase
            if (update) begin
                mosi_q  <= cur_bit;
                tx_sr_q <= lsb_q ? (tx_sr_q >> 1) : (tx_sr_q << 1);
            end
            // LSB-first frames fill from bit len-1 downwards so data ends right-aligned
            if (sample) begin
                rx_sr_q <= lsb_q ? ((rx_sr_q >> 1) | ({31'd0, miso} << len_q))
                                 : {rx_sr_q[30:0], miso};
            end
        end
    end

endmodule

// File: rtl/axi4_lite_spi_master_mc.sv
// AXI4-Lite register front end for the SPI master: handshakes, register file, status and
// interrupt. The serial engine lives in spi_master_core.
module axi4_lite_spi_master_mc #(
    parameter int unsigned CS_COUNT = 4,
    parameter int unsigned FRAME_W  = 32,
    parameter logic [7:0]  DIV_RST  = 8'd4
) (
    input  logic                s_axi_aclk_i,
    input  logic                s_axi_aresetn_i,
    input  logic [31:0]         s_axi_awaddr_i,
    input  logic                s_axi_awvalid_i,
    output logic                s_axi_awready_o,
    input  logic [31:0]         s_axi_wdata_i,
    input  logic [3:0]          s_axi_wstrb_i,
    input  logic                s_axi_wvalid_i,
    output logic                s_axi_wready_o,
    output logic [1:0]          s_axi_bresp_o,
    output logic                s_axi_bvalid_o,
    input  logic                s_axi_bready_i,
    input  logic [31:0]         s_axi_araddr_i,
    input  logic                s_axi_arvalid_i,
    output logic                s_axi_arready_o,
    output logic [31:0]         s_axi_rdata_o,
    output logic [1:0]          s_axi_rresp_o,
    output logic                s_axi_rvalid_o,
    input  logic                s_axi_rready_i,
    output logic [CS_COUNT-1:0] cs_o,
    output logic                sck_o,
    output logic                spi_mosi_o,
    input  logic                spi_miso_i,
    output logic                irq_o
);
    import axi_spi_pkg::*;

    logic        aw_rdy_q, bvalid_q, ar_rdy_q, rvalid_q, done_q;
    logic [1:0]  bresp_q, rresp_q;
    logic [31:0] rdata_q, ctrl_q, rx_q, core_rx, rd_val;
    logic [7:0]  div_q;
    logic [2:0]  wr_idx, rd_idx;
    logic        wr_hs, rd_hs, wr_ok, rd_ok, start, done_clr, busy, finish;
    logic        unused_bits;

    assign wr_idx = s_axi_awaddr_i[4:2];
    assign rd_idx = s_axi_araddr_i[4:2];
    assign wr_hs  = aw_rdy_q && s_axi_awvalid_i && s_axi_wvalid_i;
    assign rd_hs  = ar_rdy_q && s_axi_arvalid_i;

    always_comb begin
        // Config and TXDATA are locked while the engine runs
        wr_ok    = (wr_idx <= RegStatus) &&
                   !(busy && (wr_idx == RegCtrl || wr_idx == RegDiv || wr_idx == RegTxdata));
        start    = wr_hs && wr_ok && (wr_idx == RegTxdata);
        done_clr = wr_hs && wr_ok && (wr_idx == RegStatus) && s_axi_wdata_i[1];
        rd_ok    = 1'b1;
        rd_val   = 32'd0;
        case (rd_idx)
            RegCtrl:   rd_val = ctrl_q;
            RegDiv:    rd_val = {24'd0, div_q};
            RegTxdata: rd_val = 32'd0;
            RegRxdata: rd_val = rx_q;
            RegStatus: rd_val = {30'd0, done_q, busy};
            default:   rd_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
        if (!s_axi_aresetn_i) begin
            aw_rdy_q <= 1'b0;
            bvalid_q <= 1'b0;
            bresp_q  <= RespOkay;
            ctrl_q   <= 32'd0;
            div_q    <= DIV_RST;
            done_q   <= 1'b0;
            rx_q     <= 32'd0;
        end else begin
            aw_rdy_q <= s_axi_awvalid_i && s_axi_wvalid_i && !bvalid_q && !aw_rdy_q;
            if (wr_hs) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_ok ? RespOkay : RespSlverr;
            end else if (bvalid_q && s_axi_bready_i) begin
                bvalid_q <= 1'b0;
            end
            if (wr_hs && wr_ok && wr_idx == RegCtrl) begin
                ctrl_q <= apply_strb(ctrl_q, s_axi_wdata_i, s_axi_wstrb_i) & CtrlMask;
            end
            if (wr_hs && wr_ok && wr_idx == RegDiv && s_axi_wstrb_i[0]) begin
                div_q <= s_axi_wdata_i[7:0];
            end
            // Engine completion wins over a simultaneous W1C
            if (finish) begin
                done_q <= 1'b1;
                rx_q   <= core_rx;
            end else if (done_clr) begin
                done_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge s_axi_aclk_i or negedge s_axi_aresetn_i) begin
        if (!s_axi_aresetn_i) begin
            ar_rdy_q <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= 32'd0;
            rresp_q  <= RespOkay;
        end else begin
            ar_rdy_q <= s_axi_arvalid_i && !rvalid_q && !ar_rdy_q;
            if (rd_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_val;
                rresp_q  <= rd_ok ? RespOkay : RespSlverr;
            end else if (rvalid_q && s_axi_rready_i) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    assign s_axi_awready_o = aw_rdy_q;
    assign s_axi_wready_o  = aw_rdy_q;
    assign s_axi_bvalid_o  = bvalid_q;
    assign s_axi_bresp_o   = bresp_q;
    assign s_axi_arready_o = ar_rdy_q;
    assign s_axi_rvalid_o  = rvalid_q;
    assign s_axi_rdata_o   = rdata_q;
    assign s_axi_rresp_o   = rresp_q;
    assign irq_o           = done_q && ctrl_q[CtrlIrqEn];

    assign unused_bits = ^{s_axi_awaddr_i[31:5], s_axi_awaddr_i[1:0], s_axi_araddr_i[31:5],
                           s_axi_araddr_i[1:0], ctrl_q[31:21], ctrl_q[15:11], ctrl_q[7:4]};

    spi_master_core #(
        .CS_COUNT (CS_COUNT),
        .FRAME_W  (FRAME_W)
    ) u_core (
        .clk       (s_axi_aclk_i),
        .rst_n     (s_axi_aresetn_i),
        .start     (start),
        .cpol      (ctrl_q[CtrlCpol]),
        .cpha      (ctrl_q[CtrlCpha]),
        .lsb_first (ctrl_q[CtrlLsb]),
        .cs_sel    (ctrl_q[CtrlCsLo +: 3]),
        .len_m1    (ctrl_q[CtrlLenLo +: 5]),
        .div       (div_q),
        .txdata    (s_axi_wdata_i),
        .miso      (spi_miso_i),
        .busy      (busy),
        .finish    (finish),
        .rxdata    (core_rx),
        .cs        (cs_o),
        .sck       (sck_o),
        .mosi      (spi_mosi_o)
    );

endmodule
